// File: rtl/adc_readout_arbiter.sv
// adc_readout_arbiter: round-robin share of the PS readout AXIS stream between N_CH ADC streams
// Each grant emits one framed packet: a header word followed by BURST_LEN data beats.
// Ports:
//   pl_clk, rst      clock, asynchronous active-low reset
//   enable_mask      per-channel permission to compete, sampled only while idle
//   s_axis_*         N_CH upstream streams, channel i at tdata[i*DATA_W +: DATA_W]
//   m_axis_*         single downstream packet stream, tlast on the final data beat
//   active_ch        channel currently (or most recently) granted
//   busy             high while a packet is in flight (header or burst)
module adc_readout_arbiter #(
  parameter int N_CH      = 16,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 64
) (
  input  logic                   pl_clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        enable_mask,
  input  logic [N_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [N_CH-1:0]        s_axis_tvalid,
  output logic [N_CH-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]      m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic [3:0]             active_ch,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, HDR, BURST} state_t;
  localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);
  state_t state_q, state_d;
  logic [3:0] last_q, last_d, act_q, act_d, gnt, idx;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] seq_q, seq_d;
  logic [N_CH-1:0] req;
  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    req = s_axis_tvalid & enable_mask;
    gnt = last_q;
    idx = '0;
    for (int k = N_CH; k >= 1; k--) begin
      idx = 4'((int'(last_q) + k) % N_CH);
      if (req[idx]) gnt = idx;
    end
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    act_d = act_q;
    cnt_d = cnt_q;
    seq_d = seq_q;
    m_axis_tdata = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast = 1'b0;
    s_axis_tready = '0;
    case (state_q)
      IDLE: if (|req) begin
        act_d = gnt;
        last_d = gnt;
        state_d = HDR;
      end
      HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata = DATA_W'({4'hA, act_q, seq_q, 16'(BURST_LEN)});
        if (m_axis_tready) begin
          state_d = BURST;
          cnt_d = '0;
        end
      end
      BURST: begin
        m_axis_tdata = s_axis_tdata[act_q*DATA_W +: DATA_W];
        m_axis_tvalid = s_axis_tvalid[act_q];
        s_axis_tready[act_q] = m_axis_tready;
        m_axis_tlast = cnt_q == LAST_BEAT;
        if (m_axis_tvalid && m_axis_tready) begin
          cnt_d = cnt_q + 16'd1;
          if (m_axis_tlast) begin
            seq_d = seq_q + 8'd1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge pl_clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      last_q <= 4'(N_CH - 1);
      act_q <= '0;
      cnt_q <= '0;
      seq_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      act_q <= act_d;
      cnt_q <= cnt_d;
      seq_q <= seq_d;
    end
  assign active_ch = act_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_adc_readout_arbiter.sv
// tb_adc_readout_arbiter: randomized packet-level check of adc_readout_arbiter against a round-robin model
module tb_adc_readout_arbiter;
  localparam int N = 16, W = 32, BL = 4;
  logic pl_clk = 1'b0, rst = 1'b0;
  logic [N-1:0] enable_mask = '1, s_axis_tvalid = '0, s_axis_tready, b_s_tready;
  logic [N*W-1:0] s_axis_tdata;
  logic [W-1:0] m_axis_tdata, b_tdata;
  logic m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, busy, b_tvalid, b_tlast, b_busy;
  logic b_tready = 1'b1;
  logic [3:0] active_ch, b_active;
  int compared = 0, mismatched = 0;
  logic [31:0] salt;
  int src_idx [N];
  logic [N-1:0] base_valid = '1, hs = '0;
  bit gaps = 0, rdy_rand = 0, dead = 0;
  logic rdy_force = 1'b1;
  typedef struct { logic [W-1:0] d; logic l; } beat_t;
  beat_t obs [$];
  int model_cnt [N];
  int model_last = N - 1, model_seq = 0;

  adc_readout_arbiter #(.N_CH(N), .DATA_W(W), .BURST_LEN(BL)) u_dut (
    .pl_clk(pl_clk), .rst(rst), .enable_mask(enable_mask),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .active_ch(active_ch), .busy(busy));

  adc_readout_arbiter #(.N_CH(N), .DATA_W(W), .BURST_LEN(1)) u_one (
    .pl_clk(pl_clk), .rst(rst), .enable_mask(enable_mask),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(b_tready),
    .m_axis_tlast(b_tlast), .active_ch(b_active), .busy(b_busy));

  always #5 pl_clk = ~pl_clk;

  function automatic logic [31:0] data_of(input int ch, input int n);
    return {ch[3:0], n[27:0]} ^ salt;
  endfunction

  always_comb for (int i = 0; i < N; i++) s_axis_tdata[i*W +: W] = data_of(i, src_idx[i]);

  always @(negedge pl_clk) begin
    m_axis_tready = rdy_rand ? ($urandom_range(3) != 0) : rdy_force;
    for (int i = 0; i < N; i++)
      s_axis_tvalid[i] = base_valid[i] & !(gaps && busy && active_ch == 4'(i) && $urandom_range(2) == 0);
  end

  always @(negedge pl_clk) begin
    #3;
    hs = s_axis_tvalid & s_axis_tready;
    if (rst && m_axis_tvalid && m_axis_tready) obs.push_back('{m_axis_tdata, m_axis_tlast});
  end

  always @(posedge pl_clk) for (int i = 0; i < N; i++) if (rst && hs[i]) src_idx[i]++;

  task automatic get_beat(output beat_t b);
    int t = 0;
    while (obs.size() == 0 && t < 200 && !dead) begin
      @(negedge pl_clk); #4;
      t++;
    end
    if (obs.size() == 0) begin
      if (!dead) begin
        compared++; mismatched++;
        $display("FAIL beat_timeout: no output beat within 200 cycles, required one");
      end
      dead = 1;
      b = '{'0, 1'b0};
    end else b = obs.pop_front();
  endtask

  task automatic expect_packet(input logic [N-1:0] set);
    int g = -1;
    beat_t b;
    logic [W-1:0] want;
    for (int k = 1; k <= N; k++) if (g < 0 && set[(model_last + k) % N]) g = (model_last + k) % N;
    if (g < 0) g = model_last;
    want = {4'hA, 4'(g), 8'(model_seq), 16'(BL)};
    get_beat(b);
    compared++;
    if (b.d !== want || b.l !== 1'b0) begin
      mismatched++;
      $display("FAIL header: got %h last %b, required %h last 0", b.d, b.l, want);
    end
    for (int k = 0; k < BL; k++) begin
      get_beat(b);
      want = data_of(g, model_cnt[g] + k);
      compared++;
      if (b.d !== want || b.l !== (k == BL - 1)) begin
        mismatched++;
        $display("FAIL data ch%0d beat%0d: got %h last %b, required %h last %b", g, k, b.d, b.l, want, k == BL - 1);
      end
    end
    model_cnt[g] += BL;
    model_last = g;
    model_seq = (model_seq + 1) % 256;
  endtask

  task automatic quiesce(input logic [N-1:0] set);
    int t = 0;
    @(posedge pl_clk); #1;
    enable_mask = '0;
    do begin
      @(negedge pl_clk); #3;
      t++;
    end while (busy && t < 300);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL quiesce: busy %b after 300 cycles, required 0", busy);
      dead = 1;
    end
    while (obs.size() > 0) expect_packet(set);
  endtask

  task automatic config_run(input logic [N-1:0] m, input bit rr, input bit gp);
    @(posedge pl_clk); #1;
    enable_mask = m;
    base_valid = m;
    rdy_rand = rr;
    rdy_force = 1'b1;
    gaps = gp;
  endtask

  task automatic check_outputs_zero(input string name);
    compared++;
    if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, active_ch, m_axis_tdata} !== '0) begin
      mismatched++;
      $display("FAIL %s: tvalid %b tlast %b s_tready %h busy %b active %h tdata %h, required all 0",
               name, m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, active_ch, m_axis_tdata);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge pl_clk);
    #3;
    check_outputs_zero("reset");
    @(posedge pl_clk); #1;
    base_valid = '0;
    enable_mask = '0;
    @(posedge pl_clk); #1;
    rst = 1'b1;
    @(negedge pl_clk); #3;
    check_outputs_zero("after_reset");
  endtask

  task automatic test_single;
    logic [6:0] ev = 7'b1011111, el = 7'b0010000, bv = 7'b1011011, bl = 7'b0010010;
    logic [W-1:0] ed;
    config_run(16'h0001, 0, 0);
    @(negedge pl_clk);
    for (int c = 0; c < 7; c++) begin
      @(negedge pl_clk); #3;
      ed = c == 0 ? 32'hA000_0004 : c == 6 ? 32'hA001_0004 : data_of(0, c - 1);
      compared++;
      if (m_axis_tvalid !== ev[c] || m_axis_tlast !== el[c] || (c != 5 && m_axis_tdata !== ed)) begin
        mismatched++;
        $display("FAIL single cyc%0d: tvalid %b tlast %b tdata %h, required %b %b %h",
                 c, m_axis_tvalid, m_axis_tlast, m_axis_tdata, ev[c], el[c], ed);
      end
      ed = c == 0 ? 32'hA000_0001 : 32'hA001_0001;
      compared++;
      if (b_tvalid !== bv[c] || b_tlast !== bl[c] || ((c == 0 || c == 3) && b_tdata !== ed)) begin
        mismatched++;
        $display("FAIL burst1 cyc%0d: tvalid %b tlast %b tdata %h, required %b %b %h",
                 c, b_tvalid, b_tlast, b_tdata, bv[c], bl[c], ed);
      end
    end
    quiesce(16'h0001);
  endtask

  task automatic test_round_robin;
    config_run('1, 1, 1);
    for (int p = 0; p <= N; p++) expect_packet('1);
    quiesce('1);
  endtask

  task automatic test_stall;
    int t = 0;
    logic [W-1:0] d;
    logic [W-1:0] want;
    config_run(16'h0004, 0, 0);
    rdy_force = 1'b0;
    do begin
      @(negedge pl_clk); #3;
      t++;
    end while (!m_axis_tvalid && t < 20);
    d = m_axis_tdata;
    for (int c = 0; c < 5; c++) begin
      @(negedge pl_clk); #3;
      compared++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== d || s_axis_tready !== '0) begin
        mismatched++;
        $display("FAIL stall_hdr cyc%0d: tvalid %b tdata %h s_tready %h, required 1 %h 0", c, m_axis_tvalid, m_axis_tdata, s_axis_tready, d);
      end
    end
    rdy_force = 1'b1;
    @(negedge pl_clk); #3;
    @(negedge pl_clk); #3;
    rdy_force = 1'b0;
    @(negedge pl_clk); #3;
    want = data_of(2, model_cnt[2] + 1);
    for (int c = 0; c < 5; c++) begin
      compared++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== want || m_axis_tlast !== 1'b0 || s_axis_tready !== '0) begin
        mismatched++;
        $display("FAIL stall_burst cyc%0d: tvalid %b tdata %h tlast %b s_tready %h, required 1 %h 0 0",
                 c, m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready, want);
      end
      @(negedge pl_clk); #3;
    end
    rdy_force = 1'b1;
    quiesce(16'h0004);
  endtask

  task automatic test_mask_clear;
    int t = 0;
    config_run(16'h0030, 1, 1);
    do begin
      @(negedge pl_clk); #3;
      t++;
    end while (!busy && t < 20);
    repeat (3) @(negedge pl_clk);
    @(posedge pl_clk); #1;
    enable_mask = 16'h0020;
    expect_packet(16'h0030);
    repeat (3) expect_packet(16'h0020);
    quiesce(16'h0020);
  endtask

  task automatic test_reset_mid;
    int t = 0;
    config_run(16'h0080, 0, 0);
    do begin
      @(negedge pl_clk); #3;
      t++;
    end while (!busy && t < 20);
    repeat (2) @(negedge pl_clk);
    @(posedge pl_clk); #1;
    rst = 1'b0;
    enable_mask = 16'h0008;
    base_valid = 16'h0008;
    @(negedge pl_clk); #3;
    check_outputs_zero("reset_mid");
    obs.delete();
    for (int i = 0; i < N; i++) model_cnt[i] = src_idx[i];
    model_last = N - 1;
    model_seq = 0;
    @(posedge pl_clk); #1;
    rst = 1'b1;
    expect_packet(16'h0008);
    quiesce(16'h0008);
  endtask

  task automatic test_seq_wrap;
    config_run(16'h0020, 1, 1);
    for (int p = 0; p < 257; p++) expect_packet(16'h0020);
    quiesce(16'h0020);
  endtask

  initial begin
    salt = $urandom;
    test_reset;
    test_single;
    test_round_robin;
    test_stall;
    test_mask_clear;
    test_reset_mid;
    test_seq_wrap;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
